// File: rtl/mpadder_pkg.sv
// rtl/mpadder_pkg.sv - shared FSM states and sizing helpers for the chunked multi-precision adder
package mpadder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SEL
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_WIDTH  = 1027;
  localparam int DEF_CHUNK  = 172;
  localparam int DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int DEF_CNT_W  = cnt_width(DEF_NCHUNK);

endpackage

// File: rtl/mpadder_slice.sv
// rtl/mpadder_slice.sv - one CHUNK-bit combinational add/subtract slice with carry in/out
module mpadder_slice #(
  parameter int CHUNK = 172
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             inv_b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] b_eff;

  assign b_eff       = inv_b ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mpadder_chunked.sv
// rtl/mpadder_chunked.sv - chunk-serial WIDTH-bit adder/subtractor with start/busy/done handshake
// Define MPADDER_CSEL_EN for the two-lane carry-select variant (about half the latency).
module mpadder_chunked
  import mpadder_pkg::*;
#(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 172
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int N = nchunk(WIDTH, CHUNK);
  localparam int H = (N + 1) / 2;
`ifdef MPADDER_CSEL_EN
  // A single chunk has nothing to split, so it stays a one-edge operation.
  localparam bit CSEL_EN = (N > 1);
`else
  localparam bit CSEL_EN = 1'b0;
`endif
  localparam int RUN_EDGES = CSEL_EN ? H : N;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(RUN_EDGES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          accept, run, last_run;

  assign accept   = (state_q == ST_IDLE) && start;
  assign run      = (state_q == ST_RUN);
  assign last_run = run && (cnt_q == LAST);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (last_run) begin
          cnt_d = '0;
          if (CSEL_EN) begin
            state_d = ST_SEL;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SEL: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  if (!CSEL_EN) begin : g_plain
    localparam int PW = N * CHUNK;

    logic [PW-1:0]    a_q, b_q, s_q;
    logic             c_q, sub_q, ext_q;
    logic [CHUNK-1:0] sl_sum;
    logic             sl_cout;
    logic [PW:0]      full;

    mpadder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_q[CHUNK-1:0]),
      .b    (b_q[CHUNK-1:0]),
      .inv_b(sub_q),
      .cin  (c_q),
      .sum  (sl_sum),
      .cout (sl_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (accept) begin
        a_q   <= PW'(in_a);
        b_q   <= PW'(in_b);
        c_q   <= subtract;
        sub_q <= subtract;
      end else if (run) begin
        a_q <= a_q >> CHUNK;
        b_q <= b_q >> CHUNK;
        s_q <= PW'({sl_sum, s_q} >> CHUNK);
        c_q <= sl_cout;
        // Subtraction borrows exactly when the final carry is clear.
        if (last_run) ext_q <= sl_cout ^ sub_q;
      end
    end

    assign full   = {ext_q, s_q};
    assign result = full[WIDTH:0];
  end else begin : g_csel
    localparam int LW = H * CHUNK;
    localparam int PW = 2 * LW;

    logic [LW-1:0]    a_lo_q, b_lo_q, a_hi_q, b_hi_q;
    logic [LW-1:0]    s_lo_q, s_h0_q, s_h1_q;
    logic             c_lo_q, c_h0_q, c_h1_q, sub_q, ext_q;
    logic [CHUNK-1:0] sum_lo, sum_h0, sum_h1;
    logic             co_lo, co_h0, co_h1;
    logic             sel;
    logic [PW:0]      full;

    assign sel = (state_q == ST_SEL);

    mpadder_slice #(.CHUNK(CHUNK)) u_lo (
      .a(a_lo_q[CHUNK-1:0]), .b(b_lo_q[CHUNK-1:0]), .inv_b(sub_q),
      .cin(c_lo_q), .sum(sum_lo), .cout(co_lo)
    );
    mpadder_slice #(.CHUNK(CHUNK)) u_h0 (
      .a(a_hi_q[CHUNK-1:0]), .b(b_hi_q[CHUNK-1:0]), .inv_b(sub_q),
      .cin(c_h0_q), .sum(sum_h0), .cout(co_h0)
    );
    mpadder_slice #(.CHUNK(CHUNK)) u_h1 (
      .a(a_hi_q[CHUNK-1:0]), .b(b_hi_q[CHUNK-1:0]), .inv_b(sub_q),
      .cin(c_h1_q), .sum(sum_h1), .cout(co_h1)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_lo_q <= '0;
        b_lo_q <= '0;
        a_hi_q <= '0;
        b_hi_q <= '0;
        s_lo_q <= '0;
        s_h0_q <= '0;
        s_h1_q <= '0;
        c_lo_q <= 1'b0;
        c_h0_q <= 1'b0;
        c_h1_q <= 1'b0;
        sub_q  <= 1'b0;
        ext_q  <= 1'b0;
      end else if (accept) begin
        {a_hi_q, a_lo_q} <= PW'(in_a);
        {b_hi_q, b_lo_q} <= PW'(in_b);
        c_lo_q <= subtract;
        c_h0_q <= 1'b0;
        c_h1_q <= 1'b1;
        sub_q  <= subtract;
      end else if (run) begin
        a_lo_q <= a_lo_q >> CHUNK;
        b_lo_q <= b_lo_q >> CHUNK;
        a_hi_q <= a_hi_q >> CHUNK;
        b_hi_q <= b_hi_q >> CHUNK;
        s_lo_q <= LW'({sum_lo, s_lo_q} >> CHUNK);
        s_h0_q <= LW'({sum_h0, s_h0_q} >> CHUNK);
        s_h1_q <= LW'({sum_h1, s_h1_q} >> CHUNK);
        c_lo_q <= co_lo;
        c_h0_q <= co_h0;
        c_h1_q <= co_h1;
      end else if (sel) begin
        // The chosen upper lane lands in s_h0_q so result reads one fixed register set.
        if (c_lo_q) s_h0_q <= s_h1_q;
        ext_q <= sub_q ^ (c_lo_q ? c_h1_q : c_h0_q);
      end
    end

    assign full   = {ext_q, s_h0_q, s_lo_q};
    assign result = full[WIDTH:0];
  end

endmodule
